fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the control decoder.
- Holds the program counter and presents its address to the instruction ROM. The 9-bit instruction returned by the ROM feeds the decoder.
- Takes the decoder's branch flag and the ALU's compare result back from downstream, and selects the next PC from sequential, branch-LUT or halt.
- Runs a start/done handshake with the testbench or top level.

Parameters:
- PC_W, 10, program counter width; ROM depth is 2**PC_W words.
- LUT_SEL_W, 5, width of the branch-target LUT index; 32 entries.
- HALT_INSTR, 9'b111111111, instruction encoding that ends the program.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins execution from PC 0.
- instr  in  9  instruction currently addressed by pc, from the combinational ROM.
- branch_flag  in  1  decoder branchFlag for instr.
- uncond  in  1  instruction is jump; branch is taken regardless of compare result.
- cond_true  in  1  ALU compare result (beq/blt/bgt) for instr.
- target_sel  in  LUT_SEL_W  branch LUT index, taken from instr low bits by the decoder.
- pc  out  PC_W  current fetch address.
- instr_valid  out  1  instr is architecturally executing this cycle.
- branch_taken  out  1  a PC redirect happens at the next edge.
- done  out  1  program has halted.
- cycle_count  out  16  RUN-state cycle count (see Optional Feature).

Behaviour:
- Reset values: pc=0, state=IDLE, instr_valid=0, branch_taken=0, done=0, cycle_count=0.
- Reset is synchronous and overrides everything, including mid-RUN. The next state is always IDLE.
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - pc held at 0; instr_valid=0.
  - start=1 → RUN at the next edge.
- RUN:
  - instr_valid=1, combinationally.
  - taken = branch_flag & (uncond | cond_true).
  - branch_taken = taken & (instr != HALT_INSTR).
  - Next pc:
    - instr == HALT_INSTR: pc holds; go to DONE.
    - else if taken: pc = lut[target_sel], an absolute address.
    - else: pc = pc + 1.
  - start is ignored.
- DONE:
  - done=1, instr_valid=0, pc holds its halt address.
  - start=1 → pc=0 and RUN at the next edge; done drops in that same cycle.
- Latency: single-cycle execute model. One instruction retires per RUN cycle, with no bubble on a taken branch.
- Wrap-around: pc = 2**PC_W-1 with no branch → pc=0 next cycle. Execution continues with no flag.
- Halt has priority over branch when the HALT encoding coincides with branch_flag.
- X/undefined instr in RUN: no requirement; the bench must not drive X there.
- LUT entries are constants from the package. An unused index returns 0.

Optional Feature:
- Macro: FETCH_CYCLE_COUNT_EN.
- When defined:
  - cycle_count increments by 1 each RUN cycle, including the halt cycle, and saturates at 16'hFFFF.
  - It clears to 0 on reset and on the start edge that leaves IDLE/DONE.
  - It holds in DONE.
- When undefined: cycle_count is tied to 0 and no counter flops are inferred.
- The port exists in both builds.

Decomposition:
- Package fetch_pkg holds:
  - state enum fetch_state_e {IDLE, RUN, DONE};
  - PC_W and LUT_SEL_W defaults;
  - HALT_INSTR;
  - the 32-entry branch-target constant array BRANCH_LUT.
- Sub-module branch_lut: combinational lookup from target_sel to a PC_W address, indexing the package array.
- The PC register and FSM stay in fetch_unit.

Test Plan:
- Reset/start:
  - Assert reset 2 cycles → pc=0, done=0, instr_valid=0.
  - Pulse start → next cycle instr_valid=1, pc=0.
  - Then pc=1, 2, 3 on successive cycles with non-branch instr.
- Jump:
  - At pc=3 drive branch_flag=1, uncond=1, target_sel=5, with BRANCH_LUT[5]=40.
  - Required: branch_taken=1 that cycle, pc=40 next cycle.
- Conditional:
  - At pc=10 drive branch_flag=1, uncond=0, cond_true=0 → pc=11.
  - Repeat with cond_true=1, target_sel=2 (LUT=7) → pc=7.
- Halt:
  - instr=9'h1FF at pc=20, with branch_flag=1 also driven → branch_taken=0.
  - Next cycle done=1 and pc=20; pc holds for 5 further cycles.
  - With FETCH_CYCLE_COUNT_EN, cycle_count equals the RUN cycle count and then freezes.
- Restart/reset mid-run:
  - start in DONE → pc=0, done=0, RUN.
  - start during RUN at pc=6 → pc=7, with no restart.
  - reset at pc=9 → IDLE, pc=0 next edge.
- Wrap:
  - Run to pc=1023 with no branch → pc=0 next cycle; instr_valid stays 1 and done stays 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
//
// Contents: FSM state enum, PC/LUT widths, halt encoding and the constant
// branch-target table used by branch_lut.
package fetch_pkg;

   localparam int PC_W      = 10;
   localparam int LUT_SEL_W = 5;
   localparam int LUT_DEPTH = 2 ** LUT_SEL_W;
   localparam int INSTR_W   = 9;

   localparam logic [INSTR_W-1:0] HALT_INSTR = 9'b111111111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fetch_state_e;

   typedef logic [PC_W-1:0] pc_t;

   // Absolute branch targets indexed by the decoder's target_sel.
   // Entries without a program-assigned target are left at 0.
   localparam pc_t BRANCH_LUT [LUT_DEPTH] = '{
      10'd0,    10'd100,  10'd7,    10'd200,   // 0..3
      10'd512,  10'd40,   10'd1023, 10'd300,   // 4..7
      10'd10,   10'd20,   10'd128,  10'd0,     // 8..11
      10'd900,  10'd0,    10'd0,    10'd0,     // 12..15
      10'd64,   10'd0,    10'd0,    10'd0,     // 16..19
      10'd333,  10'd0,    10'd0,    10'd0,     // 20..23
      10'd0,    10'd0,    10'd0,    10'd0,     // 24..27
      10'd0,    10'd0,    10'd0,    10'd1000   // 28..31
   };

   // Sequential successor; the top PC naturally wraps to 0.
   function automatic pc_t pc_incr(input pc_t pc);
      return pc + pc_t'(1);
   endfunction

endpackage

// File: rtl/branch_lut.sv
// Branch-target lookup: maps a LUT index to an absolute PC.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows target_sel every cycle.
//
// Ports:
//   target_sel  in  LUT_SEL_W  branch LUT index from the decoder
//   target_pc   out PC_W       absolute branch destination
module branch_lut
   import fetch_pkg::*;
(
   input  logic [LUT_SEL_W-1:0] target_sel,
   output logic [PC_W-1:0]      target_pc
);

   // The index width covers the table exactly, so every index is in range.
   assign target_pc = BRANCH_LUT[target_sel];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the IDLE/RUN/DONE program FSM.
// Latency: single-cycle execute; next PC (sequential, LUT branch or hold) lands at the next edge.
// Backpressure: none; one instruction retires every RUN cycle, taken branches add no bubble.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   start           one-cycle pulse; launches execution from PC 0 (ignored in RUN)
//   instr           instruction at pc from the combinational ROM
//   branch_flag     decoder says instr is a branch
//   uncond          branch is a jump (ignores compare result)
//   cond_true       ALU compare result for instr
//   target_sel      branch LUT index
//   pc              current fetch address
//   instr_valid     instr is executing this cycle
//   branch_taken    PC redirect at the next edge
//   done            program has halted
//   cycle_count     RUN-cycle counter, saturating
//
// Build option: define FETCH_CYCLE_COUNT_EN to enable the cycle counter;
// without it cycle_count is tied to 0.
module fetch_unit
   import fetch_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [INSTR_W-1:0]   instr,
   input  logic                 branch_flag,
   input  logic                 uncond,
   input  logic                 cond_true,
   input  logic [LUT_SEL_W-1:0] target_sel,
   output logic [PC_W-1:0]      pc,
   output logic                 instr_valid,
   output logic                 branch_taken,
   output logic                 done,
   output logic [15:0]          cycle_count
);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] lut_pc;
   logic            is_halt;
   logic            taken;

   branch_lut u_branch_lut (
      .target_sel (target_sel),
      .target_pc  (lut_pc)
   );

   assign is_halt = (instr == HALT_INSTR);
   assign taken   = branch_flag & (uncond | cond_true);

   // ------------------------------------------------------------------
   // State and PC registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // ------------------------------------------------------------------
   // Next state / next PC
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         IDLE: begin
            pc_d = '0;
            if (start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            // Halt wins over a coincident branch: the PC parks on the
            // halt address so it can be inspected afterwards.
            if (is_halt) begin
               state_d = DONE;
            end else if (taken) begin
               pc_d = lut_pc;
            end else begin
               pc_d = pc_incr(pc_q);
            end
         end
         DONE: begin
            if (start) begin
               pc_d    = '0;
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      instr_valid  = 1'b0;
      branch_taken = 1'b0;
      done         = 1'b0;
      case (state_q)
         RUN: begin
            instr_valid  = 1'b1;
            branch_taken = taken & ~is_halt;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            instr_valid  = 1'b0;
         end
      endcase
   end

   assign pc = pc_q;

   // ------------------------------------------------------------------
   // Optional RUN-cycle counter
   // ------------------------------------------------------------------
`ifdef FETCH_CYCLE_COUNT_EN
   logic [15:0] cycle_count_q, cycle_count_d;

   always_comb begin
      cycle_count_d = cycle_count_q;
      case (state_q)
         RUN: begin
            // Counts the halt cycle too; saturates rather than wrapping.
            if (cycle_count_q != 16'hFFFF) begin
               cycle_count_d = cycle_count_q + 16'd1;
            end
         end
         default: begin
            // Frozen in IDLE/DONE until a start launches a new run.
            if (start) begin
               cycle_count_d = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_count_q <= '0;
      end else begin
         cycle_count_q <= cycle_count_d;
      end
   end

   assign cycle_count = cycle_count_q;
`else
   assign cycle_count = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// reset sequence, then randomized stimulus against a behavioural model.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [8:0]  instr;
   logic        branch_flag;
   logic        uncond;
   logic        cond_true;
   logic [4:0]  target_sel;
   logic [9:0]  pc;
   logic        instr_valid;
   logic        branch_taken;
   logic        done;
   logic [15:0] cycle_count;

   int n_pass  = 0;
   int n_total = 0;

   fetch_unit dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .instr        (instr),
      .branch_flag  (branch_flag),
      .uncond       (uncond),
      .cond_true    (cond_true),
      .target_sel   (target_sel),
      .pc           (pc),
      .instr_valid  (instr_valid),
      .branch_taken (branch_taken),
      .done         (done),
      .cycle_count  (cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       st;
      logic [8:0] ins;
      logic       bf;
      logic       un;
      logic       ct;
      logic [4:0] sel;
      logic [9:0] epc;
      logic       ev;
      logic       et;
      logic       ed;
   } vec_t;

   vec_t tbl[$];

   localparam logic [8:0] NOP  = 9'h000;
   localparam logic [8:0] HALT = 9'h1FF;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic add(input logic rst, input logic st, input logic [8:0] ins,
                      input logic bf, input logic un, input logic ct, input logic [4:0] sel,
                      input logic [9:0] epc, input logic ev, input logic et, input logic ed);
      vec_t v;
      v.rst = rst; v.st = st; v.ins = ins; v.bf = bf; v.un = un; v.ct = ct; v.sel = sel;
      v.epc = epc; v.ev = ev; v.et = et; v.ed = ed;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic rst, input logic st, input logic [8:0] ins,
                        input logic bf, input logic un, input logic ct, input logic [4:0] sel);
      reset = rst; start = st; instr = ins;
      branch_flag = bf; uncond = un; cond_true = ct; target_sel = sel;
   endtask

   // Counter value the bench expects given the number of RUN cycles seen.
   function automatic logic [15:0] cnt_exp(input int runs);
`ifdef FETCH_CYCLE_COUNT_EN
      return (runs > 65535) ? 16'hFFFF : 16'(runs);
`else
      return 16'd0;
`endif
   endfunction

   // Behavioural reference model state.
   bit m_running, m_halted;
   int m_pc, m_runs;

   initial begin
      int tcnt;
      drive(1'b1, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 5'd0);

      // ---------------- reset sequence ----------------
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("reset pc", 32'(pc), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset valid", 32'(instr_valid), 32'd0);
      check("reset taken", 32'(branch_taken), 32'd0);
      check("reset count", 32'(cycle_count), 32'd0);

      // ---------------- directed table ----------------
      //   rst st  instr bf un ct sel  | pc   vld tkn done
      add(0, 1, NOP,  0, 0, 0, 0,   10'd0,  0, 0, 0);  // 0  IDLE + start
      add(0, 0, NOP,  0, 0, 0, 0,   10'd0,  1, 0, 0);  // 1
      add(0, 0, NOP,  0, 0, 0, 0,   10'd1,  1, 0, 0);  // 2
      add(0, 0, NOP,  0, 0, 0, 0,   10'd2,  1, 0, 0);  // 3
      add(0, 0, NOP,  1, 1, 0, 5,   10'd3,  1, 1, 0);  // 4  jump -> 40
      add(0, 0, NOP,  1, 1, 0, 8,   10'd40, 1, 1, 0);  // 5  jump -> 10
      add(0, 0, NOP,  1, 0, 0, 2,   10'd10, 1, 0, 0);  // 6  cond false
      add(0, 0, NOP,  1, 0, 1, 2,   10'd11, 1, 1, 0);  // 7  cond true -> 7
      add(0, 0, NOP,  0, 0, 1, 2,   10'd7,  1, 0, 0);  // 8  cond w/o flag
      add(0, 0, NOP,  1, 0, 1, 9,   10'd8,  1, 1, 0);  // 9  -> 20
      add(0, 0, HALT, 1, 1, 1, 5,   10'd20, 1, 0, 0);  // 10 halt beats branch
      for (int k = 0; k < 6; k++)
         add(0, 0, NOP, 0, 0, 0, 0, 10'd20, 0, 0, 1);  // 11..16 DONE holds
      add(0, 1, NOP,  0, 0, 0, 0,   10'd20, 0, 0, 1);  // 17 restart
      add(0, 0, NOP,  0, 0, 0, 0,   10'd0,  1, 0, 0);  // 18
      for (int k = 1; k <= 5; k++)
         add(0, 0, NOP, 0, 0, 0, 0, 10'(k), 1, 0, 0);  // 19..23
      add(0, 1, NOP,  0, 0, 0, 0,   10'd6,  1, 0, 0);  // 24 start in RUN
      add(0, 0, NOP,  0, 0, 0, 0,   10'd7,  1, 0, 0);  // 25
      add(0, 0, NOP,  0, 0, 0, 0,   10'd8,  1, 0, 0);  // 26
      add(1, 0, NOP,  0, 0, 0, 0,   10'd9,  1, 0, 0);  // 27 reset mid-run
      add(0, 0, NOP,  0, 0, 0, 0,   10'd0,  0, 0, 0);  // 28 back in IDLE
      add(0, 1, NOP,  0, 0, 0, 0,   10'd0,  0, 0, 0);  // 29 start
      add(0, 0, NOP,  1, 1, 0, 6,   10'd0,  1, 1, 0);  // 30 jump -> 1023
      add(0, 0, NOP,  0, 0, 0, 0,   10'd1023, 1, 0, 0);// 31
      add(0, 0, NOP,  0, 0, 0, 0,   10'd0,  1, 0, 0);  // 32 wrapped
      add(0, 0, NOP,  0, 0, 0, 0,   10'd1,  1, 0, 0);  // 33

      tcnt = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].st, tbl[i].ins, tbl[i].bf, tbl[i].un, tbl[i].ct, tbl[i].sel);
         #1;
         check($sformatf("row%0d pc", i), 32'(pc), 32'(tbl[i].epc));
         check($sformatf("row%0d valid", i), 32'(instr_valid), 32'(tbl[i].ev));
         check($sformatf("row%0d taken", i), 32'(branch_taken), 32'(tbl[i].et));
         check($sformatf("row%0d done", i), 32'(done), 32'(tbl[i].ed));
         check($sformatf("row%0d count", i), 32'(cycle_count), 32'(cnt_exp(tcnt)));
         @(posedge clk);
         #1;
         if (tbl[i].rst) tcnt = 0;
         else if (tbl[i].ev) tcnt++;
         else if (tbl[i].st) tcnt = 0;
      end

      // ---------------- randomized run vs model ----------------
      drive(1'b1, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 5'd0);
      repeat (2) @(posedge clk);
      #1;
      m_running = 0; m_halted = 0; m_pc = 0; m_runs = 0;
      for (int c = 0; c < 3000; c++) begin
         logic       r_rst, r_st, r_bf, r_un, r_ct;
         logic [8:0] r_ins;
         logic [4:0] r_sel;
         bit         exp_take;
         r_rst = ($urandom_range(99) == 0);
         r_st  = ($urandom_range(7) == 0);
         r_ins = ($urandom_range(29) == 0) ? HALT : 9'($urandom);
         r_bf  = 1'($urandom);
         r_un  = 1'($urandom);
         r_ct  = 1'($urandom);
         r_sel = 5'($urandom);
         drive(r_rst, r_st, r_ins, r_bf, r_un, r_ct, r_sel);
         #1;
         exp_take = m_running && r_bf && (r_un || r_ct) && (r_ins != HALT);
         check($sformatf("rnd%0d pc", c), 32'(pc), 32'(m_pc));
         check($sformatf("rnd%0d valid", c), 32'(instr_valid), 32'(m_running));
         check($sformatf("rnd%0d taken", c), 32'(branch_taken), 32'(exp_take));
         check($sformatf("rnd%0d done", c), 32'(done), 32'(m_halted));
         check($sformatf("rnd%0d count", c), 32'(cycle_count), 32'(cnt_exp(m_runs)));
         @(posedge clk);
         #1;
         if (r_rst) begin
            m_running = 0; m_halted = 0; m_pc = 0; m_runs = 0;
         end else if (m_running) begin
            m_runs++;
            if (r_ins == HALT) begin
               m_running = 0; m_halted = 1;
            end else if (r_bf && (r_un || r_ct)) begin
               m_pc = int'(fetch_pkg::BRANCH_LUT[r_sel]);
            end else begin
               m_pc = (m_pc + 1) % 1024;
            end
         end else if (r_st) begin
            m_running = 1; m_halted = 0; m_pc = 0; m_runs = 0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
